// File: rtl/bresenham_line_drawer_pkg.sv
// Shared line-drawing definitions: screen geometry, coordinate/error widths and FSM states.
// Also used by the ADC conversion block and the framebuffer.
package bresenham_line_drawer_pkg;

    localparam int COORD_W       = 10;
    localparam int ERR_W         = 12;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    typedef logic [COORD_W-1:0]      coord_t;
    typedef logic signed [ERR_W-1:0] err_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PLOT  = 2'd2,
        DONE  = 2'd3
    } line_state_t;

    function automatic coord_t abs_diff(input coord_t a, input coord_t b);
        return (a >= b) ? coord_t'(a - b) : coord_t'(b - a);
    endfunction

endpackage

// File: rtl/bresenham_line_drawer.sv
// Integer Bresenham line rasteriser that issues one framebuffer pixel write per accepted cycle.
// Define LINE_CLIP_EN to suppress writes outside the 640x480 screen.
module bresenham_line_drawer
    import bresenham_line_drawer_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               bressenham_start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               bressenham_done,
    output logic               busy,
    output logic               pix_we,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    input  logic               pix_ready
);

    line_state_t state, state_next;

    coord_t lat_x0, lat_y0, end_x, end_y;
    coord_t cur_x, cur_y;
    err_t   dx, dy, err;
    logic   sx_neg, sy_neg;

    err_t                   setup_dx, setup_dy;
    logic signed [ERR_W:0]  e2, dx_ext, dy_ext;
    logic                   step_x, step_y, at_end, advance;
    err_t                   dx_term, dy_term, err_next;
    coord_t                 cur_x_next, cur_y_next;

    assign setup_dx = err_t'(abs_diff(end_x, lat_x0));
    assign setup_dy = -err_t'(abs_diff(end_y, lat_y0));

    // e2 is one bit wider than err so 2*err never wraps.
    assign e2     = {err, 1'b0};
    assign dx_ext = {dx[ERR_W-1], dx};
    assign dy_ext = {dy[ERR_W-1], dy};

    assign step_x   = (e2 >= dy_ext);
    assign step_y   = (e2 <= dx_ext);
    assign dy_term  = step_x ? dy : err_t'(0);
    assign dx_term  = step_y ? dx : err_t'(0);
    assign err_next = err + dy_term + dx_term;

    assign cur_x_next = !step_x ? cur_x : (sx_neg ? cur_x - 1'b1 : cur_x + 1'b1);
    assign cur_y_next = !step_y ? cur_y : (sy_neg ? cur_y - 1'b1 : cur_y + 1'b1);
    assign at_end     = (cur_x == end_x) && (cur_y == end_y);

`ifdef LINE_CLIP_EN
    logic plot_visible;

    assign plot_visible = (cur_x < coord_t'(SCREEN_WIDTH)) && (cur_y < coord_t'(SCREEN_HEIGHT));
    assign pix_we       = (state == PLOT) && plot_visible;
    // Off-screen pixels are skipped without waiting on the framebuffer.
    assign advance      = (state == PLOT) && (pix_ready || !plot_visible);
`else
    assign pix_we  = (state == PLOT);
    assign advance = pix_we && pix_ready;
`endif

    assign pix_x           = cur_x;
    assign pix_y           = cur_y;
    assign busy            = (state != IDLE);
    assign bressenham_done = (state == DONE);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bressenham_start) state_next = SETUP;
            SETUP:   state_next = PLOT;
            PLOT:    if (advance && at_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every datapath register is async-reset to zero; an interrupted line leaves nothing behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_x0 <= '0;
            lat_y0 <= '0;
            end_x  <= '0;
            end_y  <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            dx     <= '0;
            dy     <= '0;
            err    <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bressenham_start) begin
                        lat_x0 <= x0;
                        lat_y0 <= y0;
                        end_x  <= x1;
                        end_y  <= y1;
                    end
                end
                SETUP: begin
                    dx     <= setup_dx;
                    dy     <= setup_dy;
                    err    <= setup_dx + setup_dy;
                    sx_neg <= (end_x < lat_x0);
                    sy_neg <= (end_y < lat_y0);
                    cur_x  <= lat_x0;
                    cur_y  <= lat_y0;
                end
                PLOT: begin
                    if (advance && !at_end) begin
                        err   <= err_next;
                        cur_x <= cur_x_next;
                        cur_y <= cur_y_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bresenham_line_drawer.sv
// Directed self-checking bench for bresenham_line_drawer with hand-computed pixel lists.
// The clipped-line case is exercised only when LINE_CLIP_EN is defined.
module tb_bresenham_line_drawer;

    localparam int LINE_BUDGET = 400;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       bressenham_start;
    logic [9:0] x0, y0, x1, y1;
    logic       bressenham_done;
    logic       busy;
    logic       pix_we;
    logic [9:0] pix_x, pix_y;
    logic       pix_ready;

    int total = 0;
    int bad   = 0;

    int acc_x[$];
    int acc_y[$];
    int first_we, done_at, done_pulses, hold_errs, post_busy;

    bresenham_line_drawer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .bressenham_start (bressenham_start),
        .x0               (x0),
        .y0               (y0),
        .x1               (x1),
        .y1               (y1),
        .bressenham_done  (bressenham_done),
        .busy             (busy),
        .pix_we           (pix_we),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .pix_ready        (pix_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_pix(input string tag, input int idx, input int ex, input int ey);
        if (idx < acc_x.size())
            check($sformatf("%s[%0d]", tag, idx), acc_x[idx] * 1024 + acc_y[idx], ex * 1024 + ey);
        else
            check($sformatf("%s[%0d]", tag, idx), -1, ex * 1024 + ey);
    endtask

    // Draws one line; offsets k are cycles after the start cycle (k=0). ready_mode 1 toggles pix_ready 1-0-1-0
    // from the first pixel on. Non-zero stray_a/stray_b pulse start at those offsets; endpoints are scrambled after k=0.
    task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int ready_mode, input int stray_a, input int stray_b);
        bit stall;
        int hold_x, hold_y;
        acc_x.delete();
        acc_y.delete();
        first_we    = -1;
        done_at     = -1;
        done_pulses = 0;
        hold_errs   = 0;
        post_busy   = 0;
        stall       = 1'b0;
        hold_x      = 0;
        hold_y      = 0;
        @(posedge clk); #2;
        x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
        bressenham_start = 1'b1;
        pix_ready        = 1'b1;
        for (int k = 1; k <= LINE_BUDGET; k++) begin
            @(posedge clk); #2;
            bressenham_start = (k == stray_a) || (k == stray_b);
            x0 = 10'(k * 37); y0 = 10'(k * 53); x1 = 10'(k * 71); y1 = 10'(k * 13);
            pix_ready = (ready_mode == 0) ? 1'b1 : ((k % 2) == 0);
            @(negedge clk);
            if (stall && (!pix_we || pix_x != 10'(hold_x) || pix_y != 10'(hold_y))) hold_errs++;
            if (pix_we && first_we < 0) first_we = k;
            if (pix_we && pix_ready) begin
                acc_x.push_back(int'(pix_x));
                acc_y.push_back(int'(pix_y));
            end
            stall  = pix_we && !pix_ready;
            hold_x = int'(pix_x);
            hold_y = int'(pix_y);
            if (bressenham_done) begin
                done_pulses++;
                if (done_at < 0) done_at = k;
            end
            if (done_at >= 0 && k > done_at && busy) post_busy++;
            if (done_at >= 0 && k >= done_at + 2) break;
        end
        bressenham_start = 1'b0;
        pix_ready        = 1'b1;
    endtask

    initial begin
        int ex_a[5];
        int ey_a[5];
        int ex_e[6];
        int ey_e[6];
        int y_bad, x_changes, seen_done;

        ex_a = '{0, 1, 2, 3, 4};
        ey_a = '{0, 1, 1, 2, 2};
        ex_e = '{2, 2, 1, 1, 0, 0};
        ey_e = '{0, 1, 2, 3, 4, 5};

        reset_n          = 1'b0;
        bressenham_start = 1'b0;
        pix_ready        = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", bressenham_done, 0);
        check("rst_we", pix_we, 0);
        check("rst_px", pix_x, 0);
        check("rst_py", pix_y, 0);
        @(posedge clk); #2;
        reset_n = 1'b1;

        // Shallow line (0,0)->(4,2): hand-traced pixel list.
        run_line(0, 0, 4, 2, 0, 0, 0);
        check("a_first_we", first_we, 2);
        check("a_count", acc_x.size(), 5);
        for (int i = 0; i < 5; i++) check_pix("a_pix", i, ex_a[i], ey_a[i]);
        check("a_done_at", done_at, 7);
        check("a_post_busy", post_busy, 0);

        // Steep line with negative x step (2,0)->(0,5).
        run_line(2, 0, 0, 5, 0, 0, 0);
        check("e_count", acc_x.size(), 6);
        for (int i = 0; i < 6; i++) check_pix("e_pix", i, ex_e[i], ey_e[i]);
        check("e_done_at", done_at, 8);

        // Long steep line (0,240)->(1,100).
        run_line(0, 240, 1, 100, 0, 0, 0);
        check("b_count", acc_x.size(), 141);
        check_pix("b_first", 0, 0, 240);
        check_pix("b_last", 140, 1, 100);
        y_bad = 0;
        x_changes = 0;
        for (int i = 1; i < acc_y.size(); i++) begin
            if (acc_y[i] != acc_y[i-1] - 1) y_bad++;
            if (acc_x[i] != acc_x[i-1]) x_changes++;
        end
        check("b_y_monotonic", y_bad, 0);
        check("b_x_changes", x_changes, 1);
        check("b_done_at", done_at, 2 + 141);

        // Single-pixel line.
        run_line(5, 5, 5, 5, 0, 0, 0);
        check("d_count", acc_x.size(), 1);
        check_pix("d_pix", 0, 5, 5);
        check("d_done_at", done_at, 3);
        check("d_post_busy", post_busy, 0);

        // Reverse diagonal with back-pressure.
        run_line(10, 10, 0, 0, 1, 0, 0);
        check("c_count", acc_x.size(), 11);
        for (int i = 0; i < 11; i++) check_pix("c_pix", i, 10 - i, 10 - i);
        check("c_hold_errs", hold_errs, 0);
        check("c_done_pulses", done_pulses, 1);

        // Stray starts while busy (k=4) and during the done cycle (k=7).
        run_line(0, 0, 4, 2, 0, 4, 7);
        check("s_count", acc_x.size(), 5);
        for (int i = 0; i < 5; i++) check_pix("s_pix", i, ex_a[i], ey_a[i]);
        check("s_done_at", done_at, 7);
        check("s_post_busy", post_busy, 0);
        check("s_done_pulses", done_pulses, 1);
        run_line(5, 5, 5, 5, 0, 0, 0);
        check("s_next_first_we", first_we, 2);
        check_pix("s_next_pix", 0, 5, 5);

        // Reset asserted while pixel 3 of (0,0)->(20,0) is presented.
        @(posedge clk); #2;
        x0 = 10'd0; y0 = 10'd0; x1 = 10'd20; y1 = 10'd0;
        bressenham_start = 1'b1;
        pix_ready        = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #2;
            bressenham_start = 1'b0;
        end
        check("r_px_before", pix_x, 3);
        reset_n = 1'b0;
        #1;
        check("r_we", pix_we, 0);
        check("r_busy", busy, 0);
        check("r_px", pix_x, 0);
        check("r_done", bressenham_done, 0);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bressenham_done) seen_done++;
        end
        check("r_no_done", seen_done, 0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        run_line(0, 0, 20, 0, 0, 0, 0);
        check("r_count", acc_x.size(), 21);
        check_pix("r_first", 0, 0, 0);
        check_pix("r_last", 20, 20, 0);
        check("r_done_at", done_at, 2 + 21);

`ifdef LINE_CLIP_EN
        // Diagonal crossing the bottom-right screen corner.
        run_line(630, 470, 650, 490, 0, 0, 0);
        check("k_count", acc_x.size(), 10);
        check_pix("k_first", 0, 630, 470);
        check_pix("k_last", 9, 639, 479);
        check("k_done_at", done_at, 2 + 21);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bresenham_line_drawer.md
BRESENHAM_LINE_DRAWER -- requirements
Module: bresenham_line_drawer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic rising-edge.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: bressenham_start  in  1  one-cycle request to draw a line.
REQ-004 SHALL have ports: x0, y0, x1, y1  in  10 each  unsigned endpoints, sampled on an accepted start.
REQ-005 SHALL have ports: bressenham_done  out  1  one-cycle pulse, line complete.
REQ-006 SHALL have ports: busy  out  1  high whenever state is not IDLE.
REQ-007 SHALL have ports: pix_we  out  1  pixel write request to framebuffer.
REQ-008 SHALL have ports: pix_x  out  10; pix_y  out  10  pixel coordinate, valid while pix_we.
REQ-009 SHALL have ports: pix_ready  in  1  framebuffer accepts the write in the cycle pix_we && pix_ready.

Function
REQ-010 SHALL implement states IDLE, SETUP, PLOT, DONE.
REQ-011 SHALL accept bressenham_start only in IDLE; start in any other state, including DONE, SHALL be ignored.
REQ-012 On an accepted start, SHALL latch x0..y1 and go to SETUP; later input changes SHALL have no effect on the line.
REQ-013 SETUP SHALL compute dx=|x1-x0|, dy=-|y1-y0|, sx=+1/-1 (x1>=x0), sy=+1/-1 (y1>=y0), err=dx+dy, cur=(x0,y0), then go to PLOT.
REQ-014 err SHALL be 12-bit signed; e2=2*err SHALL be 13-bit signed; no overflow for any 10-bit endpoints.
REQ-015 Latency: start at cycle N SHALL give first pix_we at cycle N+2.
REQ-016 PLOT SHALL drive pix_we=1 with pix_x/pix_y=cur; outputs SHALL hold stable while pix_we && !pix_ready.
REQ-017 On an accepted write, if cur==(x1,y1) SHALL go to DONE; otherwise SHALL step.
REQ-018 Step rule: if e2>=dy then err+=dy and x+=sx; if e2<=dx then err+=dx and y+=sy. Both updates SHALL apply in the same cycle when both hold.
REQ-019 Pixel count SHALL equal max(dx,|dy|)+1; x0==x1 && y0==y1 SHALL give exactly one pixel.
REQ-020 DONE SHALL assert bressenham_done for exactly one cycle, drop pix_we, and return to IDLE next cycle.
REQ-021 With pix_ready held high, throughput SHALL be one pixel per cycle.

Reset
REQ-022 Reset SHALL force state IDLE, bressenham_done=0, busy=0, pix_we=0, pix_x=0, pix_y=0, internal registers 0.
REQ-023 Reset mid-line SHALL abandon the line immediately, with no done pulse.

Configuration
REQ-024 Macro LINE_CLIP_EN defined: a pixel with x>=640 or y>=480 SHALL NOT be written (pix_we=0); stepping SHALL advance one pixel per cycle regardless of pix_ready; done timing is unchanged otherwise.
REQ-025 Macro LINE_CLIP_EN undefined: every pixel SHALL be issued; no clip logic SHALL be synthesized.

Structure
REQ-026 A shared package SHALL hold SCREEN_WIDTH=640, SCREEN_HEIGHT=480, coordinate width 10, error width 12, and the state enum, shared with the ADC conversion block and the framebuffer.
REQ-027 The block SHALL be a single module with no sub-module; the step datapath is small enough to stay inline.

Verification
REQ-028 (0,240)->(1,100), pix_ready=1: pixels (0,240) through (1,100), 141 total, monotonic y, done at cycle N+2+141.
REQ-029 (5,5)->(5,5): exactly one write (5,5), done the following cycle, busy low after.
REQ-030 (10,10)->(0,0) with pix_ready toggling 1-0-1-0: 11 diagonal pixels in decreasing order, each held until accepted, no duplicate or dropped writes.
REQ-031 Start pulses during a busy line, and in the same cycle as done: ignored; the next start in IDLE is accepted with latency N+2.
REQ-032 reset_n low during pixel 3 of (0,0)->(20,0): all outputs 0 at once, no done pulse; the next line draws correctly.
REQ-033 LINE_CLIP_EN, (630,470)->(650,490): writes only (630..639, 470..479), 10 pixels, done after 21 step cycles.
